// File: rtl/pulse_round_robin_scheduler.sv
// Shares one pulse output among CHANNELS sources. Each source has a saturating pending counter,
// and the counters are drained round-robin as one-cycle pulses separated by MIN_GAP low cycles.
module pulse_round_robin_scheduler #(
    parameter int  CHANNELS            = 4,
    parameter int  PULSE_COUNTER_WIDTH = 3,
    parameter int  MIN_GAP             = 1,
    localparam int CHANNEL_INDEX_WIDTH = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic [CHANNELS-1:0]            pulse_in,
    output logic                           pulse_out,
    output logic [CHANNEL_INDEX_WIDTH-1:0] pulse_channel,
    output logic [CHANNELS-1:0]            busy,
    output logic                           pending
);
    localparam int CIW = CHANNEL_INDEX_WIDTH;
    localparam int PCW = PULSE_COUNTER_WIDTH;
    localparam int GW  = $clog2(MIN_GAP + 1);
    localparam logic [PCW-1:0] CNT_MAX  = {PCW{1'b1}};
    localparam logic [GW-1:0]  GAP_LAST = GW'(MIN_GAP - 1);
    localparam logic [CIW-1:0] LAST_CH  = CIW'(CHANNELS - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EMIT = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [CIW-1:0]       ptr_q, ptr_d;
    logic [GW-1:0]        gap_q, gap_d;
    logic [PCW-1:0]       cnt_q [CHANNELS];
    logic [PCW-1:0]       cnt_d [CHANNELS];
    logic [CHANNELS-1:0]  busy_q, busy_d;
    logic                 pulse_out_q, pulse_out_d;
    logic [CIW-1:0]       pulse_channel_q, pulse_channel_d;
    logic                 pending_q, pending_d;

    logic [CHANNELS-1:0]  nz_s;
    logic                 any_s;
    logic [CIW-1:0]       winner_s;
    logic [CIW-1:0]       scan_s;
    logic                 found_s;
    logic                 hit_s;
    logic                 grant_s;
    logic [CHANNELS-1:0]  inc_s;
    logic [CHANNELS-1:0]  dec_s;

    function automatic logic [CIW-1:0] next_ch(input logic [CIW-1:0] ch);
        return (ch == LAST_CH) ? {CIW{1'b0}} : ch + CIW'(1);
    endfunction

    // Non-zero flags of the registered counters.
    always_comb begin
        nz_s = {CHANNELS{1'b0}};
        for (int i = 0; i < CHANNELS; i++) begin
            nz_s[i] = (cnt_q[i] != {PCW{1'b0}});
        end
        any_s = |nz_s;
    end

    // Round-robin search: first non-zero channel at or after the pointer, wrapping.
    always_comb begin
        winner_s = ptr_q;
        scan_s   = ptr_q;
        found_s  = 1'b0;
        hit_s    = 1'b0;
        for (int k = 0; k < CHANNELS; k++) begin
            hit_s    = nz_s[scan_s] & ~found_s;
            winner_s = hit_s ? scan_s : winner_s;
            found_s  = found_s | hit_s;
            scan_s   = next_ch(scan_s);
        end
    end

    // Scheduler next state, output pulse and per-channel counter updates.
    always_comb begin
        state_d         = state_q;
        gap_d           = gap_q;
        ptr_d           = ptr_q;
        pulse_out_d     = 1'b0;
        pulse_channel_d = pulse_channel_q;
        grant_s         = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (any_s) begin
                    grant_s = 1'b1;
                    state_d = ST_EMIT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_EMIT: begin
                gap_d   = {GW{1'b0}};
                state_d = ST_GAP;
            end
            ST_GAP: begin
                gap_d = gap_q + GW'(1);
                if (gap_q == GAP_LAST) begin
                    if (any_s) begin
                        grant_s = 1'b1;
                        state_d = ST_EMIT;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    state_d = ST_GAP;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (grant_s) begin
            pulse_out_d     = 1'b1;
            pulse_channel_d = winner_s;
            ptr_d           = next_ch(winner_s);
        end else begin
            ptr_d = ptr_q;
        end

        // busy is always in step with the counter, so an accepted increment can never overflow.
        inc_s     = {CHANNELS{1'b0}};
        dec_s     = {CHANNELS{1'b0}};
        busy_d    = {CHANNELS{1'b0}};
        pending_d = pulse_out_d;
        for (int i = 0; i < CHANNELS; i++) begin
            inc_s[i] = pulse_in[i] & ~busy_q[i];
            dec_s[i] = grant_s & (winner_s == CIW'(i));
            case ({inc_s[i], dec_s[i]})
                2'b10:   cnt_d[i] = cnt_q[i] + PCW'(1);
                2'b01:   cnt_d[i] = cnt_q[i] - PCW'(1);
                default: cnt_d[i] = cnt_q[i];
            endcase
            busy_d[i] = (cnt_d[i] == CNT_MAX);
            pending_d = pending_d | (cnt_d[i] != {PCW{1'b0}});
        end
    end

    // State and output registers; reset discards everything pending.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q         <= ST_IDLE;
            ptr_q           <= {CIW{1'b0}};
            gap_q           <= {GW{1'b0}};
            busy_q          <= {CHANNELS{1'b0}};
            pulse_out_q     <= 1'b0;
            pulse_channel_q <= {CIW{1'b0}};
            pending_q       <= 1'b0;
            for (int i = 0; i < CHANNELS; i++) begin
                cnt_q[i] <= {PCW{1'b0}};
            end
        end else begin
            state_q         <= state_d;
            ptr_q           <= ptr_d;
            gap_q           <= gap_d;
            busy_q          <= busy_d;
            pulse_out_q     <= pulse_out_d;
            pulse_channel_q <= pulse_channel_d;
            pending_q       <= pending_d;
            for (int i = 0; i < CHANNELS; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign pulse_out     = pulse_out_q;
    assign pulse_channel = pulse_channel_q;
    assign busy          = busy_q;
    assign pending       = pending_q;

endmodule

// File: tb/tb_pulse_round_robin_scheduler.sv
// Bench for pulse_round_robin_scheduler: directed scenarios plus random traffic, all checked
// every cycle against a counting model that spaces grants by 1+MIN_GAP edges.
module tb_pulse_round_robin_scheduler;
    localparam int NCH  = 4;
    localparam int MAXC = 7;
    localparam int GAP  = 1;

    logic       clock;
    logic       reset;
    logic [3:0] pulse_in;
    logic       pulse_out;
    logic [1:0] pulse_channel;
    logic [3:0] busy;
    logic       pending;

    int checks;
    int errors;
    int m_cnt [NCH];
    int acc   [NCH];
    int seen  [NCH];
    int m_ptr;
    int m_last;
    int m_ch;
    int edge_n;
    bit m_out;
    int stepn;
    int tq [$];
    int cq [$];
    bit prev_out;

    pulse_round_robin_scheduler dut (
        .clock         (clock),
        .reset         (reset),
        .pulse_in      (pulse_in),
        .pulse_out     (pulse_out),
        .pulse_channel (pulse_channel),
        .busy          (busy),
        .pending       (pending)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference: a grant may happen whenever something is pending and at least 1+GAP edges
    // have passed since the previous grant; the winner is the first non-empty channel from the pointer.
    task automatic model_edge(input logic [3:0] pin, input logic rst);
        int win;
        int c;
        if (rst) begin
            for (int i = 0; i < NCH; i++) begin
                m_cnt[i] = 0;
                acc[i]   = 0;
            end
            m_ptr  = 0;
            m_last = edge_n - 100;
            m_out  = 1'b0;
            m_ch   = 0;
        end else begin
            win = -1;
            if (edge_n >= m_last + 1 + GAP) begin
                for (int k = 0; k < NCH; k++) begin
                    c = (m_ptr + k) % NCH;
                    if (win < 0 && m_cnt[c] > 0) win = c;
                end
            end
            for (int i = 0; i < NCH; i++) begin
                if (pin[i] && m_cnt[i] < MAXC) begin
                    m_cnt[i]++;
                    acc[i]++;
                end
                if (i == win) m_cnt[i]--;
            end
            m_out = (win >= 0);
            if (win >= 0) begin
                m_ch   = win;
                m_ptr  = (win + 1) % NCH;
                m_last = edge_n;
            end
        end
        edge_n++;
    endtask

    task automatic step(input logic [3:0] pin, input logic rst);
        logic [3:0] eb;
        logic       ep;
        pulse_in = pin;
        reset    = rst;
        @(posedge clock);
        model_edge(pin, rst);
        #1;
        eb = 4'd0;
        ep = m_out;
        for (int i = 0; i < NCH; i++) begin
            eb[i] = (m_cnt[i] == MAXC);
            ep    = ep | (m_cnt[i] != 0);
        end
        check_val("pulse_out", 32'(pulse_out), 32'(m_out));
        check_val("pulse_channel", 32'(pulse_channel), 32'(m_ch));
        check_val("busy", 32'(busy), 32'(eb));
        check_val("pending", 32'(pending), 32'(ep));
        check_val("back_to_back", 32'(prev_out & pulse_out), 32'd0);
        if (rst) begin
            for (int i = 0; i < NCH; i++) seen[i] = 0;
        end
        if (pulse_out === 1'b1) begin
            seen[pulse_channel]++;
            tq.push_back(stepn);
            cq.push_back(int'(pulse_channel));
        end
        prev_out = pulse_out;
        stepn++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(4'd0, 1'b0);
    endtask

    task automatic do_reset();
        step(4'd0, 1'b1);
        step(4'd0, 1'b1);
        tq.delete();
        cq.delete();
    endtask

    int         base;
    int         rise;
    bit         found;
    logic [3:0] rpin;
    logic       rrst;

    initial begin
        checks   = 0;
        errors   = 0;
        stepn    = 0;
        edge_n   = 0;
        prev_out = 1'b0;
        pulse_in = 4'd0;
        reset    = 1'b1;

        do_reset();
        check_val("reset_pulse_out", 32'(pulse_out), 32'd0);
        check_val("reset_channel", 32'(pulse_channel), 32'd0);
        check_val("reset_busy", 32'(busy), 32'd0);
        check_val("reset_pending", 32'(pending), 32'd0);

        // Single pulse on channel 0.
        base = stepn;
        step(4'b0001, 1'b0);
        idle(8);
        check_val("single_count", 32'(tq.size()), 32'd1);
        if (tq.size() > 0) begin
            check_val("single_latency", 32'(tq[0] - base), 32'd1);
            check_val("single_channel", 32'(cq[0]), 32'd0);
        end
        check_val("single_pending_low", 32'(pending), 32'd0);

        // Four input cycles on channel 1.
        do_reset();
        repeat (4) step(4'b0010, 1'b0);
        idle(12);
        check_val("multi_count", 32'(tq.size()), 32'd4);
        foreach (cq[j]) check_val("multi_channel", 32'(cq[j]), 32'd1);
        for (int j = 1; j < tq.size(); j++) check_val("multi_spacing", 32'(tq[j] - tq[j-1]), 32'd2);

        // All four channels at once.
        do_reset();
        step(4'b1111, 1'b0);
        idle(12);
        check_val("simul_count", 32'(tq.size()), 32'd4);
        foreach (cq[j]) check_val("simul_order", 32'(cq[j]), 32'(j));
        for (int j = 1; j < tq.size(); j++) check_val("simul_period", 32'(tq[j] - tq[j-1]), 32'd2);

        // Fairness between channels 0 and 3.
        do_reset();
        repeat (30) step(4'b1001, 1'b0);
        idle(40);
        if (cq.size() > 0) check_val("fair_first", 32'(cq[0]), 32'd0);
        for (int j = 1; j < cq.size(); j++) check_val("fair_alternate", 32'(cq[j] != cq[j-1]), 32'd1);
        check_val("fair_conserve0", 32'(seen[0]), 32'(acc[0]));
        check_val("fair_conserve3", 32'(seen[3]), 32'(acc[3]));

        // Saturation of channel 2; busy is visible to a sampler at the 13th edge after the first sample.
        do_reset();
        base = stepn;
        rise = -1;
        for (int n = 0; n < 40; n++) begin
            step(4'b0100, 1'b0);
            if (busy[2] === 1'b1) begin
                rise = stepn - 1 - base;
                break;
            end
        end
        check_val("busy_rise_step", 32'(rise), 32'd12);
        repeat (10) step(4'b0100, 1'b0);
        idle(30);
        check_val("sat_conserve", 32'(seen[2]), 32'(acc[2]));
        check_val("sat_pending_low", 32'(pending), 32'd0);

        // Reset during an output pulse.
        do_reset();
        repeat (5) step(4'b0011, 1'b0);
        found = 1'b0;
        for (int n = 0; n < 20; n++) begin
            if (pulse_out === 1'b1) begin
                found = 1'b1;
                break;
            end
            step(4'd0, 1'b0);
        end
        check_val("emit_seen", 32'(found), 32'd1);
        step(4'd0, 1'b1);
        check_val("rst_mid_pulse_out", 32'(pulse_out), 32'd0);
        check_val("rst_mid_busy", 32'(busy), 32'd0);
        check_val("rst_mid_pending", 32'(pending), 32'd0);
        tq.delete();
        cq.delete();
        idle(10);
        check_val("rst_mid_no_pulses", 32'(tq.size()), 32'd0);
        base = stepn;
        step(4'b0100, 1'b0);
        idle(4);
        check_val("rst_mid_count", 32'(tq.size()), 32'd1);
        if (tq.size() > 0) begin
            check_val("rst_mid_latency", 32'(tq[0] - base), 32'd1);
            check_val("rst_mid_channel", 32'(cq[0]), 32'd2);
        end

        // Random traffic with occasional resets.
        do_reset();
        for (int n = 0; n < 500; n++) begin
            rpin = 4'($urandom) & 4'($urandom);
            rrst = ($urandom_range(0, 79) == 0);
            step(rpin, rrst);
        end
        idle(70);
        for (int i = 0; i < NCH; i++) check_val("rand_conserve", 32'(seen[i]), 32'(acc[i]));
        check_val("rand_pending_low", 32'(pending), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
